mul_sched: RTL

- Issue-side scheduler for the single shared multiply/divide unit.
- Collects MUL/DIV ops (para, rs0, rs1) from NREQ in-order issue lanes into a small FIFO.
- Feeds ops to the mul unit one at a time, in program order.
- Tracks completion by watching the mul result buffer occupancy, and flushes everything on clear_pipeline.

---
 rtl/mul_sched_pkg.sv | 38 +++
 rtl/mul_sched_if.sv | 43 ++++
 rtl/mul_sched_fifo.sv | 55 +++++
 rtl/mul_sched.sv | 124 ++++++++++++
 4 files changed

// File: rtl/mul_sched_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the multiply/divide issue scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mul_sched_pkg;

    // Operand width and mul result buffer occupancy width, shared with the rest of the core.
    localparam int XLEN       = 32;
    localparam int MULBUF_OFF = 2;

    // RV32M funct3 encodings carried as the op selector.
    typedef enum logic [2:0] {
        F3_MUL    = 3'd0,
        F3_MULH   = 3'd1,
        F3_MULHSU = 3'd2,
        F3_MULHU  = 3'd3,
        F3_DIV    = 3'd4,
        F3_DIVU   = 3'd5,
        F3_REM    = 3'd6,
        F3_REMU   = 3'd7
    } funct3_t;

    // One queued op: funct3 plus both operands.
    typedef struct packed {
        logic [2:0]      para;
        logic [XLEN-1:0] rs0;
        logic [XLEN-1:0] rs1;
    } entry_t;

    localparam int ENTRY_W = 3 + 2 * XLEN;

    // Issue-side view of the mul unit: free to issue, or waiting for one result.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/mul_sched_if.sv
`timescale 1ns/1ps
// Bundle of issue-lane requests, mul unit issue port and scheduler status.
// Latency: n/a (wires only).
// Backpressure: req_acc tells the issue lanes how many prefix lanes were taken.
interface mul_sched_if #(
    parameter int NREQ   = 2,
    parameter int QDEPTH = 4
);
    import mul_sched_pkg::*;

    localparam int AW = $clog2(NREQ + 1);
    localparam int CW = $clog2(QDEPTH + 1);

    logic [NREQ-1:0]      req_vld;
    logic [3*NREQ-1:0]    req_para;
    logic [XLEN*NREQ-1:0] req_rs0;
    logic [XLEN*NREQ-1:0] req_rs1;
    logic [AW-1:0]        req_acc;
    logic                 clear_pipeline;
    logic                 mul_vld;
    logic [2:0]           mul_para;
    logic [XLEN-1:0]      mul_rs0;
    logic [XLEN-1:0]      mul_rs1;
    logic [MULBUF_OFF-1:0] mul_this_order;
    logic                 mul_accept;
    logic [CW-1:0]        sched_cnt;
    logic                 sched_idle;

    // Scheduler side.
    modport slave (
        input  req_vld, req_para, req_rs0, req_rs1, clear_pipeline,
        input  mul_this_order, mul_accept,
        output req_acc, mul_vld, mul_para, mul_rs0, mul_rs1, sched_cnt, sched_idle
    );

    // Issue lanes / mul unit side.
    modport master (
        output req_vld, req_para, req_rs0, req_rs1, clear_pipeline,
        output mul_this_order, mul_accept,
        input  req_acc, mul_vld, mul_para, mul_rs0, mul_rs1, sched_cnt, sched_idle
    );

endinterface

// File: rtl/mul_sched_fifo.sv
`timescale 1ns/1ps
// Multi-write (NREQ lanes), single-read circular op queue with occupancy count.
// Latency: a pushed entry is visible at the head one cycle after its push; no bypass.
// Backpressure: none internally; the caller limits push_cnt to the free space.
module mul_sched_fifo
    import mul_sched_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int QDEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic [$clog2(NREQ+1)-1:0]    push_cnt,
    input  entry_t                       push_dat [NREQ],
    input  logic                         pop,
    output entry_t                       head,
    output logic [$clog2(QDEPTH+1)-1:0]  cnt
);

    localparam int AW = $clog2(NREQ + 1);
    localparam int CW = $clog2(QDEPTH + 1);
    localparam int PW = $clog2(QDEPTH);

    entry_t          mem [QDEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;

    // Write the accepted prefix lanes into consecutive slots starting at wr_ptr.
    always_ff @(posedge clk) begin
        if (!rst && !clr) begin
            for (int i = 0; i < NREQ; i++) begin
                if (AW'(i) < push_cnt) begin
                    mem[wr_ptr + PW'(i)] <= push_dat[i];
                end
            end
        end
    end

    // Pointers wrap modulo QDEPTH; the count is tracked separately so full and empty differ.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push_cnt);
            rd_ptr <= rd_ptr + PW'(pop);
            cnt    <= cnt + CW'(push_cnt) - CW'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/mul_sched.sv
`timescale 1ns/1ps
// Issue scheduler for the shared mul/div unit: queues lane ops, issues one at a time in order.
// Latency: an op can issue the cycle after it is accepted; the next issue follows done by one cycle.
// Backpressure: req_acc caps acceptance at free FIFO space; issue waits while an op is inflight.
module mul_sched
    import mul_sched_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int QDEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    mul_sched_if.slave  bus
);

    localparam int AW = $clog2(NREQ + 1);
    localparam int CW = $clog2(QDEPTH + 1);

    entry_t                lane_dat [NREQ];
    entry_t                head;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         space;
    logic [AW-1:0]         prefix;
    logic [AW-1:0]         acc;
    logic                  run;
    logic                  issue;
    logic                  done;
    logic [MULBUF_OFF-1:0] exp_len;
    state_t                state;
    state_t                state_nxt;

    // Unpack the flat per-lane buses into queue entries.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            lane_dat[i].para = bus.req_para[3*i +: 3];
            lane_dat[i].rs0  = bus.req_rs0[XLEN*i +: XLEN];
            lane_dat[i].rs1  = bus.req_rs1[XLEN*i +: XLEN];
        end
    end

    // Count the leading valid lanes and clamp to space left before this cycle's pop.
    always_comb begin
        prefix = '0;
        run    = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            if (run && bus.req_vld[i]) begin
                prefix = prefix + AW'(1);
            end else begin
                run = 1'b0;
            end
        end
        space = CW'(QDEPTH) - cnt;
        if (bus.clear_pipeline) begin
            acc = '0;
        end else if (CW'(prefix) > space) begin
            acc = AW'(space);
        end else begin
            acc = prefix;
        end
    end

    mul_sched_fifo #(
        .NREQ   (NREQ),
        .QDEPTH (QDEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clr      (bus.clear_pipeline),
        .push_cnt (acc),
        .push_dat (lane_dat),
        .pop      (issue),
        .head     (head),
        .cnt      (cnt)
    );

    // Inflight state register; a flush drops any outstanding op without waiting for it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Issue when idle with work queued; leave BUSY when the buffer grows past its expected length.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                issue = (cnt != '0) && !bus.clear_pipeline;
                if (issue) begin
                    state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                done = bus.mul_this_order > exp_len;
                if (bus.clear_pipeline || done) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Expected occupancy next cycle if no new result lands: current count minus any commit.
    always_ff @(posedge clk) begin
        if (rst || bus.clear_pipeline) begin
            exp_len <= '0;
        end else begin
            exp_len <= bus.mul_this_order - MULBUF_OFF'(bus.mul_accept);
        end
    end

    assign bus.req_acc    = acc;
    assign bus.mul_vld    = issue;
    assign bus.mul_para   = issue ? head.para : 3'd0;
    assign bus.mul_rs0    = issue ? head.rs0  : '0;
    assign bus.mul_rs1    = issue ? head.rs1  : '0;
    assign bus.sched_cnt  = cnt;
    assign bus.sched_idle = (cnt == '0) && (state == S_IDLE);

endmodule
